// File: rtl/ex_div_if.sv
// Operand/result bundle between the EX stage and the radix-2 divider.
// The EX stage drives through the master modport; the divider uses the slave modport.
interface ex_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   stall_req_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stall_req_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stall_req_o
  );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} and holds the pipeline through its stall request.
module ex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  ex_div_if.slave  bus
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_dividend;
  logic [W-1:0]     r_divisor;
  logic [W-1:0]     r_rem;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [2*W-1:0]   r_result;
  logic             r_ready;

  logic             w_op1_neg;
  logic             w_op2_neg;
  logic [W-1:0]     w_op1_abs;
  logic [W-1:0]     w_op2_abs;
  logic [W:0]       w_shifted;
  logic [W:0]       w_diff;
  logic             w_qbit;
  logic [W-1:0]     w_rem_next;
  logic [W-1:0]     w_quot_next;
  logic [W-1:0]     w_quot_fin;
  logic [W-1:0]     w_rem_fin;

  // Magnitudes and signs only matter for signed division
  assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[W-1];
  assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[W-1];
  assign w_op1_abs = w_op1_neg ? (~bus.opdata1_i + W'(1)) : bus.opdata1_i;
  assign w_op2_abs = w_op2_neg ? (~bus.opdata2_i + W'(1)) : bus.opdata2_i;

  // One restoring step; the dividend register doubles as the quotient shift register
  assign w_shifted   = {r_rem, r_dividend[W-1]};
  assign w_diff      = w_shifted - {1'b0, r_divisor};
  assign w_qbit      = ~w_diff[W];
  assign w_rem_next  = w_qbit ? w_diff[W-1:0] : w_shifted[W-1:0];
  assign w_quot_next = {r_dividend[W-2:0], w_qbit};
  assign w_quot_fin  = r_q_neg ? (~w_quot_next + W'(1)) : w_quot_next;
  assign w_rem_fin   = r_r_neg ? (~w_rem_next + W'(1)) : w_rem_next;

  assign bus.result_o    = r_result;
  assign bus.ready_o     = r_ready;
  assign bus.stall_req_o = bus.start_i & ~r_ready & ~bus.annul_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FREE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else if (bus.annul_i) begin
      r_state <= S_FREE;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (bus.start_i) begin
            if (bus.opdata2_i == '0) begin
              r_state <= S_BY_ZERO;
            end else begin
              r_state    <= S_ON;
              r_dividend <= w_op1_abs;
              r_divisor  <= w_op2_abs;
              r_rem      <= '0;
              r_q_neg    <= w_op1_neg ^ w_op2_neg;
              r_r_neg    <= w_op1_neg;
              r_cnt      <= '0;
            end
          end
        end
        S_BY_ZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
        S_ON: begin
          r_rem      <= w_rem_next;
          r_dividend <= w_quot_next;
          r_cnt      <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_result <= {w_rem_fin, w_quot_fin};
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end
        end
        S_END: begin
          if (!bus.start_i) begin
            r_ready <= 1'b0;
            r_state <= S_FREE;
          end
        end
        default: r_state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: a driver queues expected results from an
// arithmetic reference model, a monitor checks each completed division.
module tb_ex_div;

  logic clk;
  logic reset;

  ex_div_if #(.WIDTH(32)) bus ();

  ex_div #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_res_q[$];
  int          exp_stall_q[$];
  logic [63:0] last_exp = 64'd0;

  // Reference: plain 64-bit arithmetic, truncating division, remainder takes dividend sign
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: on every rising ready_o pop and compare result and stall length
  int   stall_cnt = 0;
  logic prev_ready = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_cnt  = 0;
        prev_ready = 1'b0;
      end else begin
        if (bus.stall_req_o) stall_cnt++;
        if (bus.ready_o && !prev_ready) begin
          checks++;
          if (exp_res_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: result=%h with no division pending", bus.result_o);
          end else begin
            logic [63:0] e;
            int          es;
            e  = exp_res_q.pop_front();
            es = exp_stall_q.pop_front();
            if (bus.result_o !== e) begin
              errors++;
              $display("FAIL result: got=%h expected=%h", bus.result_o, e);
            end
            checks++;
            if (stall_cnt != es) begin
              errors++;
              $display("FAIL stall_len: got=%0d expected=%0d", stall_cnt, es);
            end
          end
          stall_cnt = 0;
        end else if (!bus.stall_req_o && !bus.ready_o) begin
          stall_cnt = 0;
        end
        prev_ready = bus.ready_o;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one division, wait for ready, optionally hold start, then release
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] e;
    bit          seen;
    e = ref_div(sgn, a, b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    exp_res_q.push_back(e);
    exp_stall_q.push_back((b == 32'd0) ? 2 : 33);
    @(posedge clk); #1;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = 1'($urandom_range(0, 1));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready_o) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ready_timeout: ready_o=%b after 40 cycles expected=1", bus.ready_o);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_ready", 64'(bus.ready_o), 64'd1);
      chk("hold_result", bus.result_o, e);
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", 64'(bus.ready_o), 64'd0);
    last_exp = e;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_stall", 64'(bus.stall_req_o), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_div(1'b0, 32'd100, 32'd7, 5);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b1, 32'd5, 32'd0, 2);
    do_div(1'b0, 32'd5, 32'd0, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_div(1'b0, 32'd3, 32'hFFFF_FFFF, 0);

    // Annul at iteration 10, then a fresh division straight from FREE
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd9;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.annul_i = 1'b1;
    #1;
    chk("annul_stall", 64'(bus.stall_req_o), 64'd0);
    @(posedge clk); #1;
    chk("annul_ready", 64'(bus.ready_o), 64'd0);
    chk("annul_result", bus.result_o, last_exp);
    do_div(1'b0, 32'd100, 32'd7, 0);

    // Asynchronous reset mid-division
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'd12345;
    bus.opdata2_i    = 32'd11;
    bus.start_i      = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    #2;
    reset       = 1'b1;
    bus.start_i = 1'b0;
    #1;
    chk("async_rst_ready", 64'(bus.ready_o), 64'd0);
    chk("async_rst_result", bus.result_o, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_stall_idle", 64'(bus.stall_req_o), 64'd0);
    bus.start_i = 1'b1;
    #1;
    chk("post_rst_stall_req", 64'(bus.stall_req_o), 64'd1);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    do_div(1'b1, 32'hFFFF_F000, 32'd13, 0);

    // Randomized operands and modes
    for (int n = 0; n < 24; n++) begin
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 200));
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_div(sgn, a, b, int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d divisions never completed, expected 0", exp_res_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle radix-2 integer divider for the EX stage. It consumes the operand values the ID/EX pipeline register delivers (`ex_reg1`/`ex_reg2`) for DIV/DIVU and drives a stall request back towards the stall controller. That request freezes the ID/EX register (`stall[2]`/`stall[3]`) until the result is ready. The result is a {remainder, quotient} pair for the HI/LO path.

## Interface

Parameters:
- `WIDTH`, default 32: operand width; the result is 2*`WIDTH`.

Ports (clock and reset first):
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with the operands.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `start_i`  in  1  the EX stage requests a division; held high until `ready_o` is seen.
- `annul_i`  in  1  abort the division in progress (flush or exception).
- `result_o`  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- `ready_o`  out  1  `result_o` is valid.
- `stall_req_o`  out  1  stall request to the pipeline stall controller.

## Operation

- There are four states: FREE, BY_ZERO, ON and END. Reset forces state FREE, `result_o`=0, `ready_o`=0, and clears the iteration counter, dividend shift register and divisor register.
- **FREE** with `start_i`=1 and `annul_i`=0:
  - If divisor = 0, go to BY_ZERO.
  - Otherwise go to ON.
  - On entry to ON, latch |dividend| and |divisor|, the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign), and clear the counter.
  - Absolute values and signs are taken only when `signed_div_i`=1; for unsigned operation the operands are latched as-is and both signs are positive.
  - Operands are sampled only on this transition; later changes to the inputs are ignored.
- **BY_ZERO**: go to END with quotient = 0 and remainder = 0.
- **ON**: each cycle performs one restoring step.
  - Shift the partial remainder left by 1, bringing in the next dividend bit (MSB first).
  - Subtract the divisor with a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the shifted value and shift in 0.
  - After WIDTH steps (counter = WIDTH-1 on the last step), go to END.
- **Entering END**:
  - Apply the signs: negate the quotient (two's complement) if its sign is negative; negate the remainder if its sign is negative.
  - Register `result_o` and set `ready_o`=1.
- **END**:
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0, go to FREE and clear `ready_o`. `result_o` retains its value until the next division completes.
- **`annul_i`=1 in any state** sends the block to FREE on the next edge with `ready_o`=0 and `result_o` unchanged. In FREE, annul takes priority over `start_i`.
- **`stall_req_o`** = `start_i` & ~`ready_o` & ~`annul_i`. It is combinational from the inputs and the registered `ready_o`.
- **Overflow**: signed 0x80000000 / 0xFFFFFFFF (-1) yields quotient 0x80000000 and remainder 0 by natural wrap; no trap is raised.

## Timing

- Nonzero divisor:
  - Edge 1 (`start_i` sampled in FREE) enters ON.
  - Edges 2 to WIDTH+1 perform the WIDTH iterations.
  - Edge WIDTH+1 (33 for WIDTH=32) enters END; `ready_o` and `result_o` are visible after it.
  - `stall_req_o` is high from the cycle `start_i` rises through the cycle before `ready_o` rises: 33 cycles for WIDTH=32.
- Zero divisor:
  - Edge 1 enters BY_ZERO.
  - Edge 2 enters END with `ready_o`=1; the stall lasts 2 cycles.
- Back-to-back divisions: `start_i` must drop for at least one cycle (END to FREE) before the next division starts.
- Asynchronous reset asserted mid-division returns all outputs to 0 immediately, without waiting for a clock edge. After release, the block is in FREE and `stall_req_o` follows `start_i`.

## Test plan

- **Unsigned divide, latency**: `signed_div_i`=0, 100 / 7, `start_i` held.
  - `ready_o` rises after the 33rd edge; `result_o` = {0x00000002, 0x0000000E}.
  - `stall_req_o` is high for exactly 33 cycles.
- **Signed divide, sign handling**:
  - -7 / 2 gives quotient 0xFFFFFFFD and remainder 0xFFFFFFFF.
  - 7 / -2 gives quotient 0xFFFFFFFD and remainder 0x00000001.
  - The same -7 / 2 operands with DIVU give quotient 0x7FFFFFFC and remainder 0x00000001.
- **Divide by zero**: 5 / 0, signed and unsigned.
  - `ready_o` is high after edge 2 and `result_o` = 0.
  - `stall_req_o` is high for 2 cycles.
- **Annul**:
  - Assert `annul_i` at iteration 10. The state is FREE next edge, `ready_o` stays 0, `stall_req_o` drops in the same cycle, and `result_o` holds its previous value.
  - A new 100 / 7 started afterwards completes correctly.
- **Overflow and extremes**:
  - Signed 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
  - Unsigned 3 / 0xFFFFFFFF gives {3, 0}.
- **Reset and handshake**:
  - Asserting `reset` mid-division clears `ready_o` and `result_o` asynchronously.
  - Holding `start_i` in END keeps `ready_o`=1 and the result stable for 5 cycles.
  - Dropping `start_i` returns to FREE after one edge with `ready_o`=0.
